multi_adder_pipe: RTL and testbench
===================================

MULTI_ADDER_PIPE -- requirements
Module: multi_adder_pipe

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, giving the number of independent adder channels (range 1..16).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the operand width per channel.
REQ-003 The block SHALL have parameter SWIDTH, default WIDTH+1, giving the result/accumulator width per channel (range 2..32).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the input beat is present.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 The block SHALL have port x, input, NUM_CH*WIDTH bits: operand x, channel i at bits [i*WIDTH +: WIDTH].
REQ-009 The block SHALL have port y, input, NUM_CH*WIDTH bits: operand y, packed as x.
REQ-010 The block SHALL have port cin, input, NUM_CH bits: carry-in per channel.
REQ-011 The block SHALL have port acc_mode, input, 1 bit: when 1, the beat accumulates into the previous result.
REQ-012 The block SHALL have port acc_clr, input, 1 bit: when 1, the prior accumulator is treated as 0 for this beat.
REQ-013 The block SHALL have port out_valid, output, 1 bit: result beat present.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result beat.
REQ-015 The block SHALL have port sum, output, NUM_CH*SWIDTH bits: registered result per channel, packed as x.
REQ-016 The block SHALL have port zero, output, NUM_CH bits: registered flag, set when the channel sum equals 0.
REQ-017 The block SHALL have port ovf, output, NUM_CH bits: registered flag, set when the channel's true result exceeded 2^SWIDTH-1.

Function
REQ-018 The pipeline SHALL advance on en = ~out_valid | out_ready, with in_ready = en; a beat is accepted when in_valid & in_ready.
REQ-019 Stage 1 SHALL, on en, register v1 = accepted, p_i = x_i + y_i + cin_i at full WIDTH+1 bits, and acc_mode/acc_clr with the beat.
REQ-020 Stage 2 SHALL, on en, load out_valid = v1; if v1=0 then sum, zero and ovf SHALL hold their values.
REQ-021 When v1=1, stage 2 SHALL compute t_i = a_i + p_i without truncation, with a_i = sum_i if staged acc_mode=1 and acc_clr=0, else 0.
REQ-022 The channel result SHALL be t_i mod 2^SWIDTH, or the saturated value when the saturation macro is defined (REQ-030), with ovf_i = (t_i > 2^SWIDTH-1) and zero_i = (stored sum_i == 0).
REQ-023 The latency SHALL be 2 cycles from acceptance to out_valid when out_ready stays high; back-to-back beats SHALL sustain 1 beat/cycle.
REQ-024 While out_valid=1 and out_ready=0, the block SHALL hold all stages, deassert in_ready, and keep sum, zero and ovf stable.
REQ-025 In accumulate mode, the accumulator SHALL be the sum register itself; beats with acc_mode=1 immediately following a stall SHALL use the held sum.
REQ-026 Channels SHALL be fully independent; the handshake, acc_mode and acc_clr SHALL be shared by all channels.

Reset
REQ-027 On rst=1, the block SHALL immediately clear v1, out_valid, all p_i, sum, zero and ovf to 0, independent of clk.
REQ-028 A beat in flight when rst asserts SHALL be discarded, and in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-029 The first accumulate beat after reset SHALL use accumulator 0.

Configuration
REQ-030 With macro MULTI_ADDER_PIPE_SAT_EN defined, an overflowing channel SHALL output 2^SWIDTH-1; undefined, it SHALL wrap modulo 2^SWIDTH. ovf SHALL be produced identically in both builds.

Verification
REQ-031 Reset/basic: with defaults, x0=200, y0=100, cin0=1, x1=0, y1=0, cin1=0, no stall -> 2 cycles later out_valid=1, sum0=301, zero0=0, ovf0=0, sum1=0, zero1=1.
REQ-032 Accumulate: SWIDTH=9, acc_clr beat with p=250, then acc_mode beat with p=250 -> sums 250, then 500 with ovf=0; a third beat with p=50 -> ovf=1 and sum=38 when wrapping, or 511 with MULTI_ADDER_PIPE_SAT_EN.
REQ-033 Back-pressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and sum stable; on release, every beat arrives exactly once, in order, with no duplicate accumulation.
REQ-034 Throughput: 16 back-to-back random beats with out_ready=1 -> 16 results in 16 consecutive cycles, each matching the reference model.
REQ-035 Mid-operation reset: assert rst with two beats in flight -> outputs go to 0 asynchronously, the in-flight beats never appear, and the next accumulate beat starts from 0.

Source files
------------

// File: rtl/multi_adder_pipe.sv
// multi_adder_pipe: NUM_CH independent two-stage adder channels sharing one valid/ready
// handshake. Stage 1 forms x+y+cin; stage 2 adds the optional accumulator (the sum register
// itself) and registers sum, zero and ovf.
// Build option: define MULTI_ADDER_PIPE_SAT_EN to saturate overflowing channels to all-ones
// instead of wrapping; ovf is reported the same way in both builds.
module multi_adder_pipe #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SWIDTH = WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*WIDTH-1:0]  x,
  input  logic [NUM_CH*WIDTH-1:0]  y,
  input  logic [NUM_CH-1:0]        cin,
  input  logic                     acc_mode,
  input  logic                     acc_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*SWIDTH-1:0] sum,
  output logic [NUM_CH-1:0]        zero,
  output logic [NUM_CH-1:0]        ovf
);

  localparam int unsigned PW = WIDTH + 1;
  // One bit wider than the larger addend so the accumulate add never truncates.
  localparam int unsigned TW = ((SWIDTH > PW) ? SWIDTH : PW) + 1;

  logic                           en;
  logic                           v1_q;
  logic                           mode_q;
  logic                           clr_q;
  logic [NUM_CH-1:0][PW-1:0]      p_q;
  logic [NUM_CH-1:0][PW-1:0]      p_d;
  logic                           out_valid_q;
  logic [NUM_CH-1:0][SWIDTH-1:0]  sum_q;
  logic [NUM_CH-1:0][SWIDTH-1:0]  sum_d;
  logic [NUM_CH-1:0]              zero_q;
  logic [NUM_CH-1:0]              zero_d;
  logic [NUM_CH-1:0]              ovf_q;
  logic [NUM_CH-1:0]              ovf_d;
  logic [NUM_CH-1:0][TW-1:0]      acc_w;
  logic [NUM_CH-1:0][TW-1:0]      t_w;

  // Whole pipeline moves together; it only stops when a result is waiting on downstream.
  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  // Stage 1 operand add per channel, full WIDTH+1 precision.
  always_comb begin
    p_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      p_d[i] = PW'(x[i*WIDTH +: WIDTH]) + PW'(y[i*WIDTH +: WIDTH]) + PW'(cin[i]);
    end
  end

  // Stage 1 register: beat valid, partial sums and the beat's accumulate controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      mode_q <= 1'b0;
      clr_q  <= 1'b0;
      p_q    <= '0;
    end else if (en) begin
      v1_q   <= in_valid;
      mode_q <= acc_mode;
      clr_q  <= acc_clr;
      p_q    <= p_d;
    end
  end

  // Stage 2 add: accumulator is the held sum register, then wrap or saturate.
  always_comb begin
    acc_w  = '0;
    t_w    = '0;
    sum_d  = sum_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      acc_w[i] = (mode_q && !clr_q) ? TW'(sum_q[i]) : '0;
      t_w[i]   = acc_w[i] + TW'(p_q[i]);
      ovf_d[i] = |t_w[i][TW-1:SWIDTH];
`ifdef MULTI_ADDER_PIPE_SAT_EN
      sum_d[i] = ovf_d[i] ? {SWIDTH{1'b1}} : t_w[i][SWIDTH-1:0];
`else
      sum_d[i] = t_w[i][SWIDTH-1:0];
`endif
      zero_d[i] = (sum_d[i] == '0);
    end
  end

  // Stage 2 register: results only update when a valid beat arrives from stage 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      zero_q      <= '0;
      ovf_q       <= '0;
    end else if (en) begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        sum_q  <= sum_d;
        zero_q <= zero_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_multi_adder_pipe.sv
// Directed bench for multi_adder_pipe at default parameters (2 channels, 8-bit operands,
// 9-bit results). Inputs change on the falling edge; outputs are read on the falling edge.
module tb_multi_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [1:0]  cin;
  logic        acc_mode;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] sum;
  logic [1:0]  zero;
  logic [1:0]  ovf;

  int n_tests = 0;
  int n_fail  = 0;

  multi_adder_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .acc_mode  (acc_mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .zero      (zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic [7:0] x0, input logic [7:0] y0,
                       input logic c0, input logic [7:0] x1, input logic [7:0] y1,
                       input logic c1, input logic m, input logic cl);
    in_valid = v;
    x        = {x1, x0};
    y        = {y1, y0};
    cin      = {c1, c0};
    acc_mode = m;
    acc_clr  = cl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || sum !== 18'd0 || zero !== 2'b00 || ovf !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_hold: out_valid=%b sum=%h zero=%b ovf=%b, want 0/0/0/0",
               out_valid, sum, zero, ovf);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    do_reset();
    @(negedge clk);
    drive(1'b1, 8'd200, 8'd100, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency1: out_valid=%b, want 0", out_valid);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || sum[8:0] !== 9'd301 || zero[0] !== 1'b0 || ovf[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ch0: valid=%b sum0=%0d zero0=%b ovf0=%b, want 1/301/0/0",
               out_valid, sum[8:0], zero[0], ovf[0]);
    end
    n_tests++;
    if (sum[17:9] !== 9'd0 || zero[1] !== 1'b1 || ovf[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ch1: sum1=%0d zero1=%b ovf1=%b, want 0/1/0",
               sum[17:9], zero[1], ovf[1]);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || sum[8:0] !== 9'd301) begin
      n_fail++;
      $display("FAIL basic_hold: valid=%b sum0=%0d, want 0/301", out_valid, sum[8:0]);
    end
  endtask

  task automatic test_accumulate();
    logic [8:0] exp3;
`ifdef MULTI_ADDER_PIPE_SAT_EN
    exp3 = 9'd511;
`else
    exp3 = 9'd38;
`endif
    do_reset();
    @(negedge clk);
    drive(1'b1, 8'd200, 8'd50, 1'b0, 8'd1, 8'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'd200, 8'd50, 1'b0, 8'd1, 8'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || sum !== {9'd1, 9'd250} || ovf !== 2'b00) begin
      n_fail++;
      $display("FAIL acc_clr_beat: valid=%b sum1=%0d sum0=%0d ovf=%b, want 1/1/250/00",
               out_valid, sum[17:9], sum[8:0], ovf);
    end
    drive(1'b1, 8'd50, 8'd0, 1'b0, 8'd1, 8'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || sum !== {9'd2, 9'd500} || ovf !== 2'b00) begin
      n_fail++;
      $display("FAIL acc_second: valid=%b sum1=%0d sum0=%0d ovf=%b, want 1/2/500/00",
               out_valid, sum[17:9], sum[8:0], ovf);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || sum !== {9'd3, exp3} || ovf !== 2'b01 || zero !== 2'b00) begin
      n_fail++;
      $display("FAIL acc_overflow: valid=%b sum1=%0d sum0=%0d ovf=%b zero=%b, want 1/3/%0d/01/00",
               out_valid, sum[17:9], sum[8:0], ovf, zero, exp3);
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] px [7];
    logic [8:0] e0 [7];
    logic [8:0] held;
    bit         held_ok;
    int         sent;
    int         got;
    int         stalls;
    px = '{8'd10, 8'd5, 8'd3, 8'd2, 8'd7, 8'd1, 8'd4};
    e0 = '{9'd10, 9'd15, 9'd18, 9'd20, 9'd27, 9'd28, 9'd32};
    held    = '0;
    held_ok = 1'b0;
    sent    = 0;
    got     = 0;
    stalls  = 0;
    do_reset();
    for (int cyc = 0; cyc < 40 && got < 7; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc < 8);
      if (sent < 7) drive(1'b1, px[sent], 8'd0, 1'b0, 8'd1, 8'd1, 1'b0, 1'b1, sent == 0);
      else in_valid = 1'b0;
      #1;
      if (!out_ready && out_valid) begin
        stalls++;
        n_tests++;
        if (in_ready !== 1'b0 || (held_ok && sum[8:0] !== held)) begin
          n_fail++;
          $display("FAIL bp_stall: in_ready=%b sum0=%0d, want 0/%0d", in_ready, sum[8:0], held);
        end
        held    = sum[8:0];
        held_ok = 1'b1;
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (sum !== {9'((got + 1) * 2), e0[got]}) begin
          n_fail++;
          $display("FAIL bp_beat%0d: sum1=%0d sum0=%0d, want %0d/%0d",
                   got, sum[17:9], sum[8:0], (got + 1) * 2, e0[got]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    n_tests++;
    if (got != 7 || stalls != 5) begin
      n_fail++;
      $display("FAIL bp_count: got=%0d stalls=%0d, want 7/5", got, stalls);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_extra: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bx0 [16];
    logic [7:0]  by0 [16];
    logic [7:0]  bx1 [16];
    logic [7:0]  by1 [16];
    logic [1:0]  bc  [16];
    logic        bm  [16];
    logic        bcl [16];
    logic [17:0] es  [16];
    logic [1:0]  eo  [16];
    logic [1:0]  ez  [16];
    int m0;
    int m1;
    int t0;
    int t1;
    m0 = 0;
    m1 = 0;
    for (int k = 0; k < 16; k++) begin
      bx0[k] = 8'($urandom_range(0, 255));
      by0[k] = 8'($urandom_range(0, 255));
      bx1[k] = 8'($urandom_range(0, 255));
      by1[k] = 8'($urandom_range(0, 255));
      bc[k]  = 2'($urandom_range(0, 3));
      bm[k]  = 1'($urandom_range(0, 1));
      bcl[k] = (k == 0) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
      t0 = ((bm[k] && !bcl[k]) ? m0 : 0) + bx0[k] + by0[k] + bc[k][0];
      t1 = ((bm[k] && !bcl[k]) ? m1 : 0) + bx1[k] + by1[k] + bc[k][1];
      eo[k] = {t1 > 511, t0 > 511};
`ifdef MULTI_ADDER_PIPE_SAT_EN
      m0 = (t0 > 511) ? 511 : t0;
      m1 = (t1 > 511) ? 511 : t1;
`else
      m0 = t0 % 512;
      m1 = t1 % 512;
`endif
      es[k] = {9'(m1), 9'(m0)};
      ez[k] = {m1 == 0, m0 == 0};
    end
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        n_tests++;
        if (out_valid !== 1'b1 || sum !== es[k-2] || ovf !== eo[k-2] || zero !== ez[k-2]) begin
          n_fail++;
          $display("FAIL b2b_beat%0d: valid=%b sum=%h ovf=%b zero=%b, want 1/%h/%b/%b",
                   k - 2, out_valid, sum, ovf, zero, es[k-2], eo[k-2], ez[k-2]);
        end
      end
      if (k < 16) drive(1'b1, bx0[k], by0[k], bc[k][0], bx1[k], by1[k], bc[k][1], bm[k], bcl[k]);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_tail: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    @(negedge clk);
    drive(1'b1, 8'd100, 8'd0, 1'b0, 8'd3, 8'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'd50, 8'd0, 1'b0, 8'd3, 8'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || sum !== {9'd3, 9'd100}) begin
      n_fail++;
      $display("FAIL mid_pre: valid=%b sum1=%0d sum0=%0d, want 1/3/100",
               out_valid, sum[17:9], sum[8:0]);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || sum !== 18'd0 || zero !== 2'b00 || ovf !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_async: valid=%b sum=%h zero=%b ovf=%b, want 0/0/0/0",
               out_valid, sum, zero, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_in_ready: in_ready=%b, want 1", in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_ghost%0d: out_valid=%b, want 0", k, out_valid);
      end
    end
    drive(1'b1, 8'd9, 8'd0, 1'b0, 8'd4, 8'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || sum !== {9'd4, 9'd9}) begin
      n_fail++;
      $display("FAIL mid_acc_from_zero: valid=%b sum1=%0d sum0=%0d, want 1/4/9",
               out_valid, sum[17:9], sum[8:0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_back_pressure();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
